// File: rtl/fpu_addsub_sched_if.sv
// Requester and result-consumer bus of the add/sub scheduler.
// Two requesters share the request lanes; the result side is a valid/ready head.
interface fpu_addsub_sched_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [9:0]  req_addr;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_addr;
    logic        res_id;

    modport master (
        output req_valid, req_op, req_a, req_b, req_addr, res_ready,
        input  req_ready, res_valid, res_data, res_addr, res_id
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_addr, res_ready,
        output req_ready, res_valid, res_data, res_addr, res_id
    );
endinterface

// File: rtl/fpu_addsub_sched.sv
// Two-requester scheduler for a fixed-latency FP subtract pipeline.
// Adds are issued as a - (-b). A shadow shift register tracks each issue
// so results are captured purely by timing; the pipeline's own return
// strobe/tag is only cross-checked. Credits cover in-flight ops plus
// buffered results, so the result FIFO can never overflow.
module fpu_addsub_sched #(
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    fpu_addsub_sched_if.slave   bus,
    output logic [31:0]         pu_adata,
    output logic [31:0]         pu_bdata,
    output logic                pu_flag,
    output logic [4:0]          pu_addr,
    input  logic [31:0]         pu_result,
    input  logic                pu_flag_ret,
    input  logic [4:0]          pu_addr_ret,
    output logic                err_mismatch
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);

    logic [CW-1:0]      credits;
    logic               rr_ptr;
    logic               gnt_id;
    logic               issue;
    logic               push;
    logic               pop;

    logic [LAT:1]       vld_pipe;
    logic [LAT:1]       id_pipe;
    logic [LAT:1][4:0]  addr_pipe;

    logic [31:0]        f_data [DEPTH];
    logic [4:0]         f_addr [DEPTH];
    logic               f_id   [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;

    logic [31:0]        sel_a;
    logic [31:0]        sel_b;

    // Arbitration: lone requester wins, otherwise the round-robin pointer decides.
    always_comb begin
        gnt_id = 1'b0;
        case (bus.req_valid)
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = rr_ptr;
            default: gnt_id = 1'b0;
        endcase
        issue         = !rst && (credits < CRED_MAX) && (|bus.req_valid);
        bus.req_ready = issue ? (2'b01 << gnt_id) : 2'b00;
    end

    // Pipeline drive: zero when idle; adds flip the sign of b.
    always_comb begin
        pu_flag  = issue;
        pu_adata = '0;
        pu_bdata = '0;
        pu_addr  = '0;
        sel_a    = gnt_id ? bus.req_a[63:32] : bus.req_a[31:0];
        sel_b    = gnt_id ? bus.req_b[63:32] : bus.req_b[31:0];
        if (issue) begin
            pu_adata = sel_a;
            pu_bdata = bus.req_op[gnt_id] ? sel_b : {~sel_b[31], sel_b[30:0]};
            pu_addr  = gnt_id ? bus.req_addr[9:5] : bus.req_addr[4:0];
        end
    end

    assign push = vld_pipe[LAT];
    assign pop  = bus.res_valid & bus.res_ready;

    // Credit counter and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= '0;
            rr_ptr  <= 1'b0;
        end else begin
            if (issue && !pop)
                credits <= credits + CW'(1);
            else if (!issue && pop)
                credits <= credits - CW'(1);
            if (issue)
                rr_ptr <= ~gnt_id;
        end
    end

    // Shadow pipeline: {valid, id, addr} travels alongside each issued op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            id_pipe   <= '0;
            addr_pipe <= '0;
        end else begin
            vld_pipe[1]  <= issue;
            id_pipe[1]   <= gnt_id;
            addr_pipe[1] <= pu_addr;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                id_pipe[i]   <= id_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (!push && pop)
                count <= count - CW'(1);
        end
    end

    // FIFO storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            f_data[wr_ptr] <= pu_result;
            f_addr[wr_ptr] <= addr_pipe[LAT];
            f_id[wr_ptr]   <= id_pipe[LAT];
        end
    end

    assign bus.res_valid = (count != '0);
    assign bus.res_data  = f_data[rd_ptr];
    assign bus.res_addr  = f_addr[rd_ptr];
    assign bus.res_id    = f_id[rd_ptr];

    // Sticky flag: pipeline return disagrees with the shadow copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_mismatch <= 1'b0;
        else if (vld_pipe[LAT] && (!pu_flag_ret || (pu_addr_ret != addr_pipe[LAT])))
            err_mismatch <= 1'b1;
    end
endmodule

// File: tb/tb_fpu_addsub_sched.sv
// Randomized bench for fpu_addsub_sched with a queue-based reference model
// and a behavioural fixed-latency pipeline model.
module tb_fpu_addsub_sched;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pu_adata, pu_bdata, pu_result;
    logic        pu_flag, pu_flag_ret, err_mismatch;
    logic [4:0]  pu_addr, pu_addr_ret;

    fpu_addsub_sched_if bus();

    fpu_addsub_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .pu_adata(pu_adata), .pu_bdata(pu_bdata), .pu_flag(pu_flag), .pu_addr(pu_addr),
        .pu_result(pu_result), .pu_flag_ret(pu_flag_ret), .pu_addr_ret(pu_addr_ret),
        .err_mismatch(err_mismatch)
    );

    always #5 clk = ~clk;

    // Pipeline model result: exact for the 1.0 + 2.0 case, a scrambled token otherwise.
    function automatic logic [31:0] pm_fn(input logic [31:0] a, input logic [31:0] bd);
        if (a == 32'h3F80_0000 && bd == 32'hC000_0000) return 32'h4040_0000;
        return (a ^ {bd[15:0], bd[31:16]}) + 32'h0123_4567;
    endfunction

    // Fixed-latency pipeline model; corrupt forces the returned tag to 7.
    logic        corrupt = 1'b0;
    logic        pm_flag [1:LAT];
    logic [31:0] pm_res  [1:LAT];
    logic [4:0]  pm_addr [1:LAT];
    always @(posedge clk) begin
        pm_flag[1] <= pu_flag;
        pm_res[1]  <= pm_fn(pu_adata, pu_bdata);
        pm_addr[1] <= corrupt ? 5'd7 : pu_addr;
        for (int i = 2; i <= LAT; i++) begin
            pm_flag[i] <= pm_flag[i-1];
            pm_res[i]  <= pm_res[i-1];
            pm_addr[i] <= pm_addr[i-1];
        end
    end
    assign pu_flag_ret = pm_flag[LAT];
    assign pu_result   = pm_res[LAT];
    assign pu_addr_ret = pm_addr[LAT];

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        id;
        int          rdy;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          rr_m = 0;
    int          err_at = -1;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_iss;
    logic [31:0] last_bdata;
    logic        last_rv;
    logic [31:0] last_rd;
    logic [4:0]  last_ra;
    logic        last_rid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input logic [1:0] v, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [9:0] ad, input logic rr);
        int          g;
        logic        erv;
        logic [31:0] ea, eb, bs;
        logic [4:0]  ead;
        exp_t        e;
        bus.req_valid = v; bus.req_op = op; bus.req_a = a; bus.req_b = b;
        bus.req_addr = ad; bus.res_ready = rr;
        #1;
        erv = (q.size() > 0) && (q[0].rdy <= cyc);
        g = -1;
        if (q.size() < DEPTH) begin
            if (v == 2'b01) g = 0;
            else if (v == 2'b10) g = 1;
            else if (v == 2'b11) g = rr_m;
        end
        chk("req_ready", bus.req_ready, (g < 0) ? 0 : ((g == 0) ? 1 : 2));
        chk("pu_flag", pu_flag, g >= 0);
        if (g >= 0) begin
            ea  = a[32*g +: 32];
            bs  = b[32*g +: 32];
            ead = ad[5*g +: 5];
            eb  = op[g] ? bs : (bs ^ 32'h8000_0000);
            chk("pu_adata", pu_adata, ea);
            chk("pu_bdata", pu_bdata, eb);
            chk("pu_addr", pu_addr, ead);
            last_bdata = pu_bdata;
            n_iss++;
        end else begin
            chk("pu_idle", {pu_adata, pu_bdata, pu_addr}, 0);
        end
        chk("res_valid", bus.res_valid, erv);
        if (erv) begin
            chk("res_data", bus.res_data, q[0].data);
            chk("res_addr", bus.res_addr, q[0].addr);
            chk("res_id", bus.res_id, q[0].id);
        end
        chk("err_mismatch", err_mismatch, (err_at >= 0) && (cyc >= err_at));
        last_rv = bus.res_valid; last_rd = bus.res_data;
        last_ra = bus.res_addr;  last_rid = bus.res_id;
        if (erv && rr) e = q.pop_front();
        if (g >= 0) begin
            e.data = pm_fn(ea, eb); e.addr = ead; e.id = g[0]; e.rdy = cyc + LAT + 1;
            q.push_back(e);
            rr_m = 1 - g;
            if (corrupt && err_at < 0) err_at = cyc + LAT + 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.req_valid = 2'b11; bus.res_ready = 1'b1;
        repeat (n) begin
            #1;
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_res_valid", bus.res_valid, 0);
            chk("rst_pu_flag", pu_flag, 0);
            chk("rst_err", err_mismatch, 0);
            cyc++;
            @(negedge clk);
        end
        rst = 1'b0;
        q.delete(); rr_m = 0; err_at = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(2'b00, 2'b00, 64'h0, 64'h0, 10'h0, 1'b1);
    endtask

    task automatic rnd_step(input logic [1:0] v, input logic rr);
        step(v, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 10'($urandom), rr);
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        bus.req_addr = '0; bus.res_ready = 1'b0;
        @(negedge clk);
        do_reset(3);

        // 1.0 + 2.0 from requester 0, tag 5
        n_iss = 0;
        step(2'b01, 2'b00, {32'h0, 32'h3F80_0000}, {32'h0, 32'h4000_0000}, {5'd0, 5'd5}, 1'b1);
        chk("t1_bdata", last_bdata, 32'hC000_0000);
        idle(2);
        step(2'b00, 2'b00, 64'h0, 64'h0, 10'h0, 1'b1);
        chk("t1_head", {last_rv, last_rd, last_ra, last_rid}, {1'b1, 32'h4040_0000, 5'd5, 1'b0});
        idle(2);

        // both requesters continuously, consumer always ready
        n_iss = 0;
        repeat (20) rnd_step(2'b11, 1'b1);
        chk("rr_issues", n_iss, 20);
        idle(LAT + 3);

        // consumer stalled: credits run out after DEPTH issues
        n_iss = 0;
        repeat (8) rnd_step(2'b01, 1'b0);
        chk("fill_issues", n_iss, DEPTH);
        repeat (10) rnd_step(2'b01, 1'b1);
        idle(LAT + DEPTH + 2);

        // random traffic with random backpressure
        repeat (300) rnd_step(2'($urandom), ($urandom_range(0, 3) != 0));
        idle(LAT + DEPTH + 2);

        // reset one cycle after an issue: that result must never show
        step(2'b01, 2'b00, {32'h0, 32'h1234_5678}, {32'h0, 32'h0BAD_F00D}, {5'd0, 5'd9}, 1'b1);
        do_reset(1);
        n_iss = 0;
        repeat (8) rnd_step(2'b01, 1'b0);
        chk("post_rst_issues", n_iss, DEPTH);
        idle(LAT + DEPTH + 2);

        // pipeline returns the wrong tag: sticky error until reset
        corrupt = 1'b1;
        step(2'b01, 2'b01, {32'h0, 32'h4100_0000}, {32'h0, 32'h3F00_0000}, {5'd0, 5'd5}, 1'b1);
        corrupt = 1'b0;
        idle(LAT + 2);
        repeat (10) rnd_step(2'($urandom), 1'b1);
        idle(LAT + DEPTH + 2);
        do_reset(2);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fpu_addsub_sched.md
FPU_ADDSUB_SCHED -- requirements
Module: fpu_addsub_sched

Interface
REQ-001 SHALL have parameter LAT, default 2: fixed latency in cycles from pu_flag sampled high to pu_flag_ret high.
REQ-002 SHALL have parameter DEPTH, default 4: result FIFO entries, which is also the total credit count.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  2  bit N: requester N presents an operation.
REQ-006 req_ready  out  2  bit N: requester N is granted this cycle.
REQ-007 req_op  in  2  bit N: 1 = subtract (a-b), 0 = add (a+b).
REQ-008 req_a  in  64  requester N operand a at [32N+31:32N], IEEE single.
REQ-009 req_b  in  64  requester N operand b at [32N+31:32N], IEEE single.
REQ-010 req_addr  in  10  requester N destination register at [5N+4:5N].
REQ-011 pu_adata  out  32  operand a to the subtract pipeline.
REQ-012 pu_bdata  out  32  operand b to the subtract pipeline.
REQ-013 pu_flag  out  1  issue strobe to the pipeline.
REQ-014 pu_addr  out  5  destination tag to the pipeline.
REQ-015 pu_result  in  32  pipeline result.
REQ-016 pu_flag_ret  in  1  pipeline returned strobe.
REQ-017 pu_addr_ret  in  5  pipeline returned tag.
REQ-018 res_valid  out  1  result FIFO head valid.
REQ-019 res_ready  in  1  consumer accepts the head.
REQ-020 res_data / res_addr / res_id  out  32/5/1  head result, destination, and requester index.
REQ-021 err_mismatch  out  1  sticky pipeline-return check error.

Function
REQ-022 Handshake: issue occurs when req_valid[N] and req_ready[N] are both 1; at most one req_ready bit is 1 per cycle.
REQ-023 Issue permit: issue is permitted only when credit count < DEPTH; otherwise req_ready = 00.
REQ-024 Credit count: equals in-flight ops plus FIFO occupancy; +1 on issue, -1 on pop (res_valid & res_ready), unchanged when both occur in the same cycle.
REQ-025 Arbitration, single requester: when only one requester is valid, that requester is granted.
REQ-026 Arbitration, both requesters: when both are valid, the requester at the round-robin pointer is granted; after every issue the pointer moves to the non-granted requester.
REQ-027 Pipeline drive on issue, same cycle, combinational from the granted request:
- pu_flag = 1;
- pu_adata = a;
- pu_addr = addr;
- pu_bdata = b when op = 1, or {~b[31], b[30:0]} when op = 0.
REQ-028 Pipeline drive with no issue: pu_flag, pu_adata, pu_bdata and pu_addr are all 0.
REQ-029 Shadow pipeline: a LAT-deep shadow shift register carries {valid, id, addr} for each issue; its valid bits reset to 0.
REQ-030 FIFO push: the FIFO is pushed exactly when the shadow output is valid, with data = pu_result, addr = shadow addr, id = shadow id; pu_flag_ret is not used for the push.
REQ-031 Mismatch check: when the shadow output is valid and (pu_flag_ret != 1 or pu_addr_ret != shadow addr), err_mismatch SHALL set and stay 1 until reset.
REQ-032 FIFO ordering: the FIFO is first-in first-out; results leave in issue order regardless of requester.
REQ-033 Latency: issue in cycle T with an empty FIFO gives res_valid = 1 in cycle T+LAT+1.
REQ-034 Throughput: one issue per cycle is sustained while res_ready = 1.
REQ-035 FIFO full: push while full cannot occur because of credit gating; push and pop in the same cycle keep occupancy unchanged.
REQ-036 Idle head: res_data, res_addr and res_id are don't-care while res_valid = 0.

Reset
REQ-037 Reset values: while rst = 1, req_ready = 00, res_valid = 0, pu_flag = 0, err_mismatch = 0, credits = 0, FIFO is empty, shadow valid bits = 0, pointer = requester 0.
REQ-038 Reset mid-operation: reset during operation discards all in-flight and buffered results, and pipeline returns arriving after reset is released are ignored.

Verification
REQ-039 Bench SHALL cover: req0 add, a=0x3F800000, b=0x40000000, addr=5, pipeline model returns 0x40400000 -> pu_bdata=0xC0000000 in the issue cycle; res_valid at T+3 with res_data=0x40400000, res_addr=5, res_id=0.
REQ-040 Bench SHALL cover: both requesters valid continuously, res_ready=1 -> grants 0,1,0,1...; one issue per cycle; results in issue order.
REQ-041 Bench SHALL cover: res_ready=0, req0 valid continuously -> exactly 4 issues, then req_ready=00; raise res_ready -> 4 results in order, then issue resumes; credits never exceed 4.
REQ-042 Bench SHALL cover: rst pulsed one cycle after an issue -> that result never appears; after release, 4 issues are accepted with res_ready=0.
REQ-043 Bench SHALL cover: pipeline model returns pu_addr_ret=7 for an op issued with addr=5 -> err_mismatch=1 from the next cycle and held until rst.
